// File: rtl/cim_mac_sequencer.sv
// Command sequencer for a compute-in-memory MAC macro: streams weights into the banks,
// issues MAC or readback strobes, waits out the macro latency and holds the result.
module cim_mac_sequencer #(
  parameter int unsigned CORE_NUM         = 16,
  parameter int unsigned XIN_BIT_WIDTH    = 11,
  parameter int unsigned MEM_BIT_WIDTH    = 8,
  parameter int unsigned MEM_ADR_WIDTH    = 2,
  parameter int unsigned OUTPUT_BIT_WIDTH = 22,
  parameter int unsigned MAC_LATENCY      = 2,
  parameter int unsigned READ_LATENCY     = 2
) (
  input  logic                                CLK,
  input  logic                                NRST,
  input  logic                                CMD_VALID,
  output logic                                CMD_READY,
  input  logic [1:0]                          CMD_OP,
  input  logic [$clog2(CORE_NUM)-1:0]         CMD_BANK,
  input  logic [MEM_ADR_WIDTH-1:0]            CMD_ADR,
  input  logic [CORE_NUM*XIN_BIT_WIDTH-1:0]   CMD_XIN,
  input  logic                                W_VALID,
  output logic                                W_READY,
  input  logic [MEM_BIT_WIDTH-1:0]            W_DATA,
  output logic                                RES_VALID,
  input  logic                                RES_READY,
  output logic [OUTPUT_BIT_WIDTH-1:0]         RES_DATA,
  output logic                                RES_ERR,
  output logic                                BUSY,
  output logic                                M_WEB,
  output logic [$clog2(CORE_NUM)-1:0]         M_BANKA,
  output logic [MEM_ADR_WIDTH-1:0]            M_ADRA,
  output logic [MEM_BIT_WIDTH-1:0]            M_D,
  output logic                                M_REB,
  output logic [$clog2(CORE_NUM)-1:0]         M_BANKB,
  output logic [MEM_ADR_WIDTH-1:0]            M_ADRB,
  output logic                                M_ENCB,
  output logic [CORE_NUM*XIN_BIT_WIDTH-1:0]   M_XIN,
  input  logic [OUTPUT_BIT_WIDTH-1:0]         M_Q
);

  localparam int unsigned BANK_W  = $clog2(CORE_NUM);
  localparam int unsigned LAT_MAX = (MAC_LATENCY > READ_LATENCY) ? MAC_LATENCY : READ_LATENCY;
  localparam int unsigned LAT_W   = $clog2(LAT_MAX + 2);
  localparam logic [1:0]  OpLoad  = 2'b00;
  localparam logic [1:0]  OpMac   = 2'b01;
  localparam logic [1:0]  OpRead  = 2'b10;

  typedef enum logic [2:0] {StIdle, StLoad, StIssue, StWait, StHold} state_e;

  state_e                              state_q, state_d;
  logic [1:0]                          op_q, op_d;
  logic [BANK_W-1:0]                   bank_q, bank_d;
  logic [MEM_ADR_WIDTH-1:0]            adr_q, adr_d;
  logic [CORE_NUM*XIN_BIT_WIDTH-1:0]   xin_q, xin_d;
  logic [BANK_W-1:0]                   bank_cnt_q, bank_cnt_d;
  logic [LAT_W-1:0]                    lat_cnt_q, lat_cnt_d;
  logic [LAT_W-1:0]                    lat_target;
  logic [OUTPUT_BIT_WIDTH-1:0]         res_data_d;
  logic                                res_err_d;
  logic                                m_web_d, m_reb_d, m_encb_d;
  logic [BANK_W-1:0]                   m_banka_d, m_bankb_d;
  logic [MEM_ADR_WIDTH-1:0]            m_adra_d, m_adrb_d;
  logic [MEM_BIT_WIDTH-1:0]            m_d_d;
  logic [CORE_NUM*XIN_BIT_WIDTH-1:0]   m_xin_d;

  assign CMD_READY  = (state_q == StIdle);
  assign W_READY    = (state_q == StLoad);
  assign RES_VALID  = (state_q == StHold);
  assign BUSY       = (state_q != StIdle);
  assign lat_target = (op_q == OpMac) ? LAT_W'(MAC_LATENCY) : LAT_W'(READ_LATENCY);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    bank_d     = bank_q;
    adr_d      = adr_q;
    xin_d      = xin_q;
    bank_cnt_d = bank_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    res_data_d = RES_DATA;
    res_err_d  = RES_ERR;
    m_web_d    = 1'b1;
    m_reb_d    = 1'b1;
    m_encb_d   = 1'b1;
    m_banka_d  = M_BANKA;
    m_adra_d   = M_ADRA;
    m_d_d      = M_D;
    m_bankb_d  = M_BANKB;
    m_adrb_d   = M_ADRB;
    m_xin_d    = M_XIN;

    case (state_q)
      StIdle: begin
        if (CMD_VALID) begin
          op_d   = CMD_OP;
          bank_d = CMD_BANK;
          adr_d  = CMD_ADR;
          xin_d  = CMD_XIN;
          if (CMD_OP == OpLoad) begin
            state_d    = StLoad;
            bank_cnt_d = '0;
          end else if (CMD_OP == OpMac || CMD_OP == OpRead) begin
            state_d   = StIssue;
            lat_cnt_d = '0;
          end else begin
            state_d    = StHold;
            res_data_d = '0;
            res_err_d  = 1'b1;
          end
        end
      end
      StLoad: begin
        if (W_VALID) begin
          m_web_d   = 1'b0;
          m_banka_d = bank_cnt_q;
          m_adra_d  = adr_q;
          m_d_d     = W_DATA;
          // Counter parks at 0 after the last bank instead of wrapping.
          if (bank_cnt_q == BANK_W'(CORE_NUM - 1)) begin
            state_d    = StIdle;
            bank_cnt_d = '0;
          end else begin
            bank_cnt_d = bank_cnt_q + 1'b1;
          end
        end
      end
      StIssue: begin
        m_adrb_d  = adr_q;
        if (op_q == OpMac) begin
          m_encb_d = 1'b0;
          m_xin_d  = xin_q;
        end else begin
          m_reb_d   = 1'b0;
          m_bankb_d = bank_q;
        end
        state_d   = StWait;
        lat_cnt_d = '0;
      end
      StWait: begin
        // First WAIT cycle is the strobe cycle; M_Q is sampled once lat_target more have passed.
        if (lat_cnt_q == lat_target) begin
          state_d   = StHold;
          res_err_d = 1'b0;
          if (op_q == OpMac) begin
            res_data_d = M_Q;
          end else begin
            res_data_d = {{(OUTPUT_BIT_WIDTH - MEM_BIT_WIDTH){1'b0}}, M_Q[MEM_BIT_WIDTH-1:0]};
          end
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (RES_READY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state_q    <= StIdle;
      op_q       <= '0;
      bank_q     <= '0;
      adr_q      <= '0;
      xin_q      <= '0;
      bank_cnt_q <= '0;
      lat_cnt_q  <= '0;
      RES_DATA   <= '0;
      RES_ERR    <= 1'b0;
      M_WEB      <= 1'b1;
      M_REB      <= 1'b1;
      M_ENCB     <= 1'b1;
      M_BANKA    <= '0;
      M_ADRA     <= '0;
      M_D        <= '0;
      M_BANKB    <= '0;
      M_ADRB     <= '0;
      M_XIN      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      bank_q     <= bank_d;
      adr_q      <= adr_d;
      xin_q      <= xin_d;
      bank_cnt_q <= bank_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      RES_DATA   <= res_data_d;
      RES_ERR    <= res_err_d;
      M_WEB      <= m_web_d;
      M_REB      <= m_reb_d;
      M_ENCB     <= m_encb_d;
      M_BANKA    <= m_banka_d;
      M_ADRA     <= m_adra_d;
      M_D        <= m_d_d;
      M_BANKB    <= m_bankb_d;
      M_ADRB     <= m_adrb_d;
      M_XIN      <= m_xin_d;
    end
  end

endmodule

// File: tb/tb_cim_mac_sequencer.sv
// Bench for cim_mac_sequencer: behavioural macro model, write scoreboard on the macro port
// and result scoreboard on the result handshake.
module tb_cim_mac_sequencer;

  localparam int unsigned CN = 16;
  localparam int unsigned XW = 11;
  localparam int unsigned MW = 8;
  localparam int unsigned AW = 2;
  localparam int unsigned OW = 22;
  localparam int unsigned ML = 2;
  localparam int unsigned RL = 2;
  localparam int unsigned BW = 4;

  logic              CLK = 1'b0;
  logic              NRST = 1'b0;
  logic              CMD_VALID = 1'b0;
  logic              CMD_READY;
  logic [1:0]        CMD_OP = '0;
  logic [BW-1:0]     CMD_BANK = '0;
  logic [AW-1:0]     CMD_ADR = '0;
  logic [CN*XW-1:0]  CMD_XIN = '0;
  logic              W_VALID = 1'b0;
  logic              W_READY;
  logic [MW-1:0]     W_DATA = '0;
  logic              RES_VALID;
  logic              RES_READY = 1'b0;
  logic [OW-1:0]     RES_DATA;
  logic              RES_ERR;
  logic              BUSY;
  logic              M_WEB, M_REB, M_ENCB;
  logic [BW-1:0]     M_BANKA, M_BANKB;
  logic [AW-1:0]     M_ADRA, M_ADRB;
  logic [MW-1:0]     M_D;
  logic [CN*XW-1:0]  M_XIN;
  logic [OW-1:0]     M_Q = '0;

  always #5 CLK = ~CLK;

  cim_mac_sequencer #(
    .CORE_NUM(CN), .XIN_BIT_WIDTH(XW), .MEM_BIT_WIDTH(MW), .MEM_ADR_WIDTH(AW),
    .OUTPUT_BIT_WIDTH(OW), .MAC_LATENCY(ML), .READ_LATENCY(RL)
  ) dut (
    .CLK(CLK), .NRST(NRST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP), .CMD_BANK(CMD_BANK),
    .CMD_ADR(CMD_ADR), .CMD_XIN(CMD_XIN),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA), .RES_ERR(RES_ERR),
    .BUSY(BUSY),
    .M_WEB(M_WEB), .M_BANKA(M_BANKA), .M_ADRA(M_ADRA), .M_D(M_D),
    .M_REB(M_REB), .M_BANKB(M_BANKB), .M_ADRB(M_ADRB),
    .M_ENCB(M_ENCB), .M_XIN(M_XIN), .M_Q(M_Q)
  );

  typedef struct packed {logic [BW-1:0] bank; logic [AW-1:0] adr; logic [MW-1:0] data;} wr_t;
  typedef struct packed {logic [OW-1:0] data; logic err;} res_t;

  int n_checks = 0;
  int n_fail = 0;
  int web_cnt = 0, reb_cnt = 0, encb_cnt = 0;
  wr_t exp_wr[$];
  res_t exp_res[$];
  logic [MW-1:0] w_model [CN][1 << AW];
  logic [CN*XW-1:0] exp_xin = '0;

  // Macro model: weight array, two-cycle MAC / readback; readback sets junk above the word.
  logic [MW-1:0] mem [CN][1 << AW];
  logic [OW-1:0] stage_q = '0;
  logic          stage_vld = 1'b0;

  function automatic logic [OW-1:0] macro_mac(input logic [CN*XW-1:0] x, input logic [AW-1:0] a);
    logic [OW-1:0] acc = '0;
    for (int c = 0; c < CN; c++) acc += OW'(x[c*XW +: XW]) * OW'(mem[c][a]);
    return acc;
  endfunction

  always @(posedge CLK) begin
    stage_vld <= 1'b0;
    if (!M_WEB) mem[M_BANKA][M_ADRA] <= M_D;
    if (!M_ENCB) begin
      stage_q   <= macro_mac(M_XIN, M_ADRB);
      stage_vld <= 1'b1;
    end else if (!M_REB) begin
      stage_q   <= {14'h15A5, mem[M_BANKB][M_ADRB]};
      stage_vld <= 1'b1;
    end
    if (stage_vld) M_Q <= stage_q;
  end

  // Strobe monitor: exclusivity, write scoreboard, MAC activations.
  always @(negedge CLK) begin
    wr_t e, got;
    n_checks++;
    if (({2'b0, ~M_WEB} + {2'b0, ~M_REB} + {2'b0, ~M_ENCB}) > 3'd1) begin
      n_fail++;
      $display("FAIL strobe_overlap: WEB=%b REB=%b ENCB=%b, required at most one low",
               M_WEB, M_REB, M_ENCB);
    end
    if (M_WEB === 1'b0) begin
      web_cnt++;
      n_checks++;
      got = {M_BANKA, M_ADRA, M_D};
      if (exp_wr.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: bank=%0d adr=%0d d=%0h, required no write",
                 M_BANKA, M_ADRA, M_D);
      end else begin
        e = exp_wr.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL write: bank=%0d adr=%0d d=%0h, required bank=%0d adr=%0d d=%0h",
                   got.bank, got.adr, got.data, e.bank, e.adr, e.data);
        end
      end
    end
    if (M_ENCB === 1'b0) begin
      encb_cnt++;
      n_checks++;
      if (M_XIN !== exp_xin) begin
        n_fail++;
        $display("FAIL mac_xin: got %h, required %h", M_XIN, exp_xin);
      end
    end
    if (M_REB === 1'b0) reb_cnt++;
  end

  function automatic logic [OW-1:0] exp_mac(input logic [CN*XW-1:0] x, input int a);
    int s = 0;
    for (int c = 0; c < CN; c++) s += int'(x[c*XW +: XW]) * int'(w_model[c][a]);
    return OW'(s);
  endfunction

  function automatic logic [CN*XW-1:0] rand_xin();
    logic [CN*XW-1:0] x;
    for (int c = 0; c < CN; c++) x[c*XW +: XW] = XW'($urandom);
    return x;
  endfunction

  task automatic do_reset();
    NRST = 1'b0;
    CMD_VALID = 1'b0;
    W_VALID = 1'b0;
    RES_READY = 1'b0;
    repeat (2) @(negedge CLK);
    NRST = 1'b1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [BW-1:0] bank,
                          input logic [AW-1:0] adr, input logic [CN*XW-1:0] xin);
    int n = 0;
    CMD_VALID = 1'b1;
    CMD_OP = op;
    CMD_BANK = bank;
    CMD_ADR = adr;
    CMD_XIN = xin;
    while (CMD_READY !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    n_checks++;
    if (CMD_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd_accept: CMD_READY=%b after %0d cycles, required 1", CMD_READY, n);
    end
    @(negedge CLK);
    CMD_VALID = 1'b0;
  endtask

  // Waits for a result, compares it with the scoreboard, stalls 'hold' cycles, then accepts.
  task automatic take_result(input string name, input int exp_lat, input int hold);
    int cyc = 0;
    res_t e, got;
    while (RES_VALID !== 1'b1 && cyc < 100) begin
      @(negedge CLK);
      cyc++;
    end
    n_checks++;
    if (RES_VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: RES_VALID=%b after %0d cycles, required 1", name, RES_VALID, cyc);
    end
    n_checks++;
    if (cyc != exp_lat) begin
      n_fail++;
      $display("FAIL %s_latency: %0d cycles after accept, required %0d", name, cyc, exp_lat);
    end
    e = (exp_res.size() != 0) ? exp_res.pop_front() : '0;
    got = {RES_DATA, RES_ERR};
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s_result: data=%h err=%b, required data=%h err=%b",
               name, got.data, got.err, e.data, e.err);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      n_checks++;
      if ({RES_VALID, CMD_READY, RES_DATA, RES_ERR} !== {1'b1, 1'b0, e}) begin
        n_fail++;
        $display("FAIL %s_hold: valid=%b cmd_ready=%b data=%h err=%b, required 1 0 %h %b",
                 name, RES_VALID, CMD_READY, RES_DATA, RES_ERR, e.data, e.err);
      end
    end
    RES_READY = 1'b1;
    n_checks++;
    if (CMD_READY !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_accept_cycle_ready: CMD_READY=%b, required 0", name, CMD_READY);
    end
    @(negedge CLK);
    RES_READY = 1'b0;
    n_checks++;
    if ({RES_VALID, CMD_READY, BUSY} !== 3'b010) begin
      n_fail++;
      $display("FAIL %s_release: valid/ready/busy=%b, required 010", name,
               {RES_VALID, CMD_READY, BUSY});
    end
  endtask

  task automatic test_reset();
    int s0;
    do_reset();
    s0 = web_cnt + reb_cnt + encb_cnt;
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if ({CMD_READY, W_READY, RES_VALID, RES_ERR, BUSY, M_WEB, M_REB, M_ENCB} !== 8'b1000_0111
          || {RES_DATA, M_BANKA, M_ADRA, M_D, M_BANKB, M_ADRB, M_XIN} !== '0) begin
        n_fail++;
        $display("FAIL reset_state cycle %0d: ctl=%b data=%h, required ctl=10000111 data=0", i,
                 {CMD_READY, W_READY, RES_VALID, RES_ERR, BUSY, M_WEB, M_REB, M_ENCB}, RES_DATA);
      end
      @(negedge CLK);
    end
    n_checks++;
    if (web_cnt + reb_cnt + encb_cnt != s0) begin
      n_fail++;
      $display("FAIL reset_idle_strobes: %0d strobes, required 0", web_cnt + reb_cnt + encb_cnt - s0);
    end
  endtask

  // seed 0 loads 2 into every bank; otherwise bank i gets i*seed+1.
  task automatic test_load(input logic [AW-1:0] adr, input int seed, input bit gapped);
    int w0 = web_cnt;
    logic [MW-1:0] d;
    send_cmd(2'b00, '0, adr, '0);
    for (int i = 0; i < CN; i++) begin
      d = (seed == 0) ? MW'(2) : MW'(i * seed + 1);
      W_VALID = 1'b1;
      W_DATA = d;
      n_checks++;
      if (W_READY !== 1'b1) begin
        n_fail++;
        $display("FAIL load_w_ready beat %0d: W_READY=%b, required 1", i, W_READY);
      end
      exp_wr.push_back({BW'(i), adr, d});
      w_model[i][adr] = d;
      @(negedge CLK);
      W_VALID = 1'b0;
      if (gapped) @(negedge CLK);
    end
    repeat (2) @(negedge CLK);
    n_checks++;
    if (web_cnt - w0 != CN || exp_wr.size() != 0) begin
      n_fail++;
      $display("FAIL load_count: %0d writes, %0d missing, required %0d writes 0 missing",
               web_cnt - w0, exp_wr.size(), CN);
    end
    n_checks++;
    if ({BUSY, W_READY, CMD_READY} !== 3'b001) begin
      n_fail++;
      $display("FAIL load_done: busy/w_ready/cmd_ready=%b, required 001", {BUSY, W_READY, CMD_READY});
    end
  endtask

  task automatic test_mac(input logic [AW-1:0] adr, input logic [CN*XW-1:0] xin,
                          input logic [OW-1:0] want, input bit use_want);
    int e0 = encb_cnt;
    exp_xin = xin;
    exp_res.push_back({use_want ? want : exp_mac(xin, int'(adr)), 1'b0});
    send_cmd(2'b01, '0, adr, xin);
    take_result("mac", ML + 2, 0);
    n_checks++;
    if (encb_cnt - e0 != 1) begin
      n_fail++;
      $display("FAIL mac_pulses: %0d ENCB pulses, required 1", encb_cnt - e0);
    end
  endtask

  task automatic test_readback(input logic [BW-1:0] bank, input logic [AW-1:0] adr, input int hold);
    int r0 = reb_cnt;
    exp_res.push_back({OW'(w_model[bank][adr]), 1'b0});
    send_cmd(2'b10, bank, adr, rand_xin());
    take_result("readback", RL + 2, hold);
    n_checks++;
    if (reb_cnt - r0 != 1) begin
      n_fail++;
      $display("FAIL readback_pulses: %0d REB pulses, required 1", reb_cnt - r0);
    end
    n_checks++;
    if (M_XIN !== exp_xin) begin
      n_fail++;
      $display("FAIL xin_hold: M_XIN=%h, required %h", M_XIN, exp_xin);
    end
  endtask

  task automatic test_illegal();
    int s0 = web_cnt + reb_cnt + encb_cnt;
    exp_res.push_back({{OW{1'b0}}, 1'b1});
    send_cmd(2'b11, 4'd3, 2'd1, rand_xin());
    take_result("illegal", 0, 2);
    n_checks++;
    if (web_cnt + reb_cnt + encb_cnt != s0) begin
      n_fail++;
      $display("FAIL illegal_strobes: %0d strobes, required 0", web_cnt + reb_cnt + encb_cnt - s0);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [MW-1:0] d;
    send_cmd(2'b00, '0, 2'd2, '0);
    for (int i = 0; i < 7; i++) begin
      d = MW'(8'h40 + i);
      W_VALID = 1'b1;
      W_DATA = d;
      exp_wr.push_back({BW'(i), 2'd2, d});
      w_model[i][2] = d;
      @(negedge CLK);
    end
    W_VALID = 1'b0;
    NRST = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({M_WEB, M_REB, M_ENCB, BUSY, CMD_READY, W_READY} !== 6'b111010 || exp_wr.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_load: strobes/busy/ready=%b missing=%0d, required 111010 0",
               {M_WEB, M_REB, M_ENCB, BUSY, CMD_READY, W_READY}, exp_wr.size());
    end
    NRST = 1'b1;
    @(negedge CLK);
    test_load(2'd2, 7, 1'b0);
  endtask

  task automatic test_reset_mid_wait();
    int e0 = encb_cnt;
    exp_xin = rand_xin();
    send_cmd(2'b01, '0, 2'd1, exp_xin);
    @(negedge CLK);
    NRST = 1'b0;
    @(negedge CLK);
    NRST = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if ({RES_VALID, BUSY, CMD_READY} !== 3'b001) begin
        n_fail++;
        $display("FAIL reset_mid_wait cycle %0d: valid/busy/ready=%b, required 001", i,
                 {RES_VALID, BUSY, CMD_READY});
      end
      @(negedge CLK);
    end
    n_checks++;
    if (encb_cnt - e0 != 1) begin
      n_fail++;
      $display("FAIL reset_mid_wait_pulses: %0d ENCB pulses, required 1", encb_cnt - e0);
    end
  endtask

  initial begin
    for (int b = 0; b < CN; b++)
      for (int a = 0; a < (1 << AW); a++) w_model[b][a] = '0;
    test_reset();
    test_load(2'd0, 0, 1'b1);
    test_mac(2'd0, {CN{11'd3}}, 22'h000060, 1'b1);
    test_readback(4'd5, 2'd0, 7);
    test_illegal();
    test_load(2'd1, 37, 1'b0);
    test_mac(2'd1, rand_xin(), '0, 1'b0);
    test_mac(2'd0, rand_xin(), '0, 1'b0);
    test_readback(4'd15, 2'd1, 0);
    test_reset_mid_load();
    test_mac(2'd2, rand_xin(), '0, 1'b0);
    test_readback(4'd3, 2'd2, 1);
    test_reset_mid_wait();
    test_mac(2'd2, rand_xin(), '0, 1'b0);
    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cim_mac_sequencer.md
CIM_MAC_SEQUENCER -- requirements
Module: cim_mac_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- CORE_NUM, 16, number of macro banks/cores
- XIN_BIT_WIDTH, 11, per-core activation width
- MEM_BIT_WIDTH, 8, weight word width
- MEM_ADR_WIDTH, 2, word address width per bank
- OUTPUT_BIT_WIDTH, 22, macro Q width
- MAC_LATENCY, 2, cycles from ENCB low to valid Q
- READ_LATENCY, 2, cycles from REB low to valid Q
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- CLK in 1: single clock, rising edge
- NRST in 1: reset, synchronous, active-low
- CMD_VALID / CMD_READY in / out 1: command handshake
- CMD_OP in 2: 00 load weights, 01 MAC, 10 readback, 11 illegal
- CMD_BANK in $clog2(CORE_NUM): readback bank
- CMD_ADR in MEM_ADR_WIDTH: word address for all ops
- CMD_XIN in CORE_NUM*XIN_BIT_WIDTH: MAC activations
- W_VALID / W_READY in / out 1: weight stream handshake
- W_DATA in MEM_BIT_WIDTH: weight word
- RES_VALID / RES_READY out / in 1: result handshake
- RES_DATA out OUTPUT_BIT_WIDTH: result
- RES_ERR out 1: result is for an illegal op
- BUSY out 1: high in any state other than IDLE
- M_WEB, M_BANKA, M_ADRA, M_D out: macro write port (widths as macro)
- M_REB, M_BANKB, M_ADRB out: macro read port
- M_ENCB out 1: macro compute enable, active-low
- M_XIN out CORE_NUM*XIN_BIT_WIDTH: macro activations
- M_Q in OUTPUT_BIT_WIDTH: macro output

Function
REQ-003 All macro-side outputs SHALL be registered and driven directly from flops.
REQ-004 The FSM SHALL have exactly the states IDLE, LOAD, ISSUE, WAIT, HOLD.
REQ-005 CMD_READY SHALL be 1 only in IDLE; on accept, CMD_OP, CMD_BANK, CMD_ADR and CMD_XIN SHALL be captured.
REQ-006 In IDLE, an accepted op 00 SHALL go to LOAD with the bank counter at 0.
REQ-007 In IDLE, an accepted op 01 or op 10 SHALL go to ISSUE.
REQ-008 In IDLE, an accepted op 11 SHALL go to HOLD with RES_DATA=0 and RES_ERR=1.
REQ-009 LOAD: W_READY=1. For each W_VALID&&W_READY beat, the next cycle SHALL have M_WEB=0, M_BANKA=counter, M_ADRA=captured adr and M_D=W_DATA, and the counter SHALL increment.
REQ-010 LOAD: a cycle without a beat SHALL drive M_WEB=1 (stall, no write).
REQ-011 LOAD: after the beat for bank CORE_NUM-1, the FSM SHALL return to IDLE with W_READY=0; a load produces no result.
REQ-012 ISSUE, op 01: for exactly one cycle, M_ENCB=0, M_ADRB=captured adr and M_XIN=captured xin; M_XIN SHALL hold its value until the next MAC issue.
REQ-013 ISSUE, op 10: for exactly one cycle, M_REB=0, M_BANKB=captured bank and M_ADRB=captured adr.
REQ-014 WAIT SHALL count MAC_LATENCY (op 01) or READ_LATENCY (op 10) cycles after the strobe cycle, then sample M_Q.
REQ-015 The sampled value SHALL be stored as follows: op 01 stores all of M_Q in RES_DATA; op 10 stores M_Q[MEM_BIT_WIDTH-1:0] zero-extended; RES_ERR=0 in both cases.
REQ-016 HOLD: RES_VALID=1, and RES_DATA/RES_ERR SHALL stay stable until RES_READY=1.
REQ-017 HOLD: on RES_READY=1, the FSM SHALL go to IDLE and RES_VALID SHALL drop the next cycle.
REQ-018 A new command SHALL NOT be accepted in the cycle in which the result is accepted.
REQ-019 M_WEB, M_REB and M_ENCB SHALL never be low in the same cycle; at most one macro strobe is active per cycle.
REQ-020 Counters SHALL NOT wrap: the bank counter is meaningful only for 0..CORE_NUM-1, and the latency counter saturates at its target.

Reset
REQ-021 When NRST=0 at a CLK edge, the FSM SHALL enter IDLE and the following SHALL be set: M_WEB=M_REB=M_ENCB=1; all other M_* outputs 0; CMD_READY=1; W_READY=0; RES_VALID=0; RES_DATA=0; RES_ERR=0; BUSY=0; counters 0.
REQ-022 Reset mid-LOAD, mid-WAIT or in HOLD SHALL discard the job with no further macro strobes; writes already issued are not undone.

Verification
REQ-023 Reset then idle: all outputs hold their REQ-021 values, and no strobe goes low in 20 cycles.
REQ-024 Load op at adr 0 with W_DATA=2 for all 16 beats, W_VALID gapped every other cycle: exactly 16 M_WEB=0 cycles, with M_BANKA 0..15 in order and M_D=2; BUSY drops afterwards.
REQ-025 Run REQ-024, then MAC op at adr 0 with all xin=3, macro model present: a single M_ENCB=0 pulse, then RES_VALID with RES_DATA=22'h000060, exactly MAC_LATENCY+2 cycles after accept.
REQ-026 Readback op, bank 5, adr 0, after REQ-024: RES_DATA=22'h000002; with RES_READY held 0 for 7 cycles, RES_VALID and RES_DATA stay stable and CMD_READY stays 0.
REQ-027 Op 11: no macro strobe; RES_VALID with RES_ERR=1 and RES_DATA=0.
REQ-028 NRST pulsed low after 7 load beats: the strobes return high the next cycle, and a following fresh load restarts at M_BANKA=0.
